// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard/flush controller.
// The datapath side uses the master modport; pipeline_ctrl uses the slave modport.
interface pipeline_ctrl_if;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [3:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       mem_busy;

  logic       pc_wr;
  logic       ifid_wr;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       pipe_hold;
  logic [1:0] state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_mem_read, ex_branch_taken, mem_busy,
    input  pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_mem_read, ex_branch_taken, mem_busy,
    output pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold, state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-busy freeze.
// Define PIPELINE_CTRL_STALL_CNT_EN to add the saturating stall_cnt output.
module pipeline_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_ctrl_if.slave   pif
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_BAD        = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYC - 1);
  localparam bit         FLUSH_MULTI = (FLUSH_CYC > 1);

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] fcnt_reg;
  logic [2:0] fcnt_next;

  logic       en_pc;
  logic       en_ifid;
  logic       do_flush;
  logic       do_bubble;
  logic       do_hold;

  // Load-use detection, one comparator per source operand.
  logic [3:0] src_rs  [2];
  logic       src_use [2];
  logic [1:0] src_hit;
  logic       lu;

  assign src_rs[0]  = pif.id_rs1;
  assign src_rs[1]  = pif.id_rs2;
  assign src_use[0] = pif.id_use_rs1;
  assign src_use[1] = pif.id_use_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] && (src_rs[gi] == pif.ex_rd);
    end
  endgenerate

  assign lu = pif.ex_mem_read && (|src_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      fcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    en_pc      = 1'b1;
    en_ifid    = 1'b1;
    do_flush   = 1'b0;
    do_bubble  = 1'b0;
    do_hold    = 1'b0;

    case (state_reg)
      ST_RUN, ST_LOAD_STALL: begin
        state_next = ST_RUN;
        if (pif.ex_branch_taken) begin
          do_flush   = 1'b1;
          do_bubble  = 1'b1;
          fcnt_next  = FLUSH_LOAD;
          state_next = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
        end else if (lu && (state_reg == ST_RUN)) begin
          // LOAD_STALL masks lu so a single load never stalls twice.
          en_pc      = 1'b0;
          en_ifid    = 1'b0;
          do_bubble  = 1'b1;
          state_next = ST_LOAD_STALL;
        end
      end

      ST_FLUSH: begin
        do_flush = 1'b1;
        if (fcnt_reg > 3'd1) begin
          fcnt_next = fcnt_reg - 3'd1;
        end else begin
          fcnt_next  = '0;
          state_next = ST_RUN;
        end
      end

      default: begin
        // Unreachable encoding: emit NOPs and recover to RUN unconditionally.
        state_next = ST_RUN;
        fcnt_next  = '0;
        en_pc      = 1'b0;
        en_ifid    = 1'b0;
        do_flush   = 1'b1;
        do_bubble  = 1'b1;
      end
    endcase

    if (pif.mem_busy && (state_reg != ST_BAD)) begin
      state_next = state_reg;
      fcnt_next  = fcnt_reg;
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      do_flush   = 1'b0;
      do_bubble  = 1'b0;
      do_hold    = 1'b1;
    end

    // Reset overrides outputs asynchronously so the datapath loads NOPs.
    if (!rst_n) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      do_flush  = 1'b1;
      do_bubble = 1'b1;
      do_hold   = 1'b0;
    end
  end

  assign pif.pc_wr       = en_pc;
  assign pif.ifid_wr     = en_ifid;
  assign pif.ifid_flush  = do_flush;
  assign pif.idex_bubble = do_bubble;
  assign pif.pipe_hold   = do_hold;
  assign pif.state       = state_reg;

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (!en_pc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  // CNT_W only sizes the stall counter, which is not built here.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl with FLUSH_CYC=3 and a 3-bit stall counter.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl_if pif ();

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [2:0] stall_cnt;
`endif

  pipeline_ctrl #(
    .FLUSH_CYC (3),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pif       (pif)
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_stall = 0;

  // Expected vector layout: {pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold, state}.
  function automatic logic [6:0] mk(bit pc, bit ifid, bit fl, bit bub, bit hold, logic [1:0] st);
    return {pc, ifid, fl, bub, hold, st};
  endfunction

  localparam logic [6:0] RSTV  = 7'b0011000;
  localparam logic [6:0] RUNV  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001000;
  localparam logic [6:0] LSV   = 7'b1100001;
  localparam logic [6:0] BRV   = 7'b1111000;
  localparam logic [6:0] FLV   = 7'b1110010;

  task automatic idle();
    pif.id_rs1          = 4'd0;
    pif.id_rs2          = 4'd0;
    pif.id_use_rs1      = 1'b0;
    pif.id_use_rs2      = 1'b0;
    pif.ex_rd           = 4'd0;
    pif.ex_mem_read     = 1'b0;
    pif.ex_branch_taken = 1'b0;
    pif.mem_busy        = 1'b0;
  endtask

  task automatic lu_rs2(input logic [3:0] r);
    pif.ex_mem_read = 1'b1;
    pif.ex_rd       = r;
    pif.id_rs2      = r;
    pif.id_use_rs2  = 1'b1;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic check(input string tag, input logic [6:0] v);
    exp_t       e;
    logic [6:0] obs;
    sb.push_back('{tag, v});
    #2;
    e   = sb.pop_front();
    obs = {pif.pc_wr, pif.ifid_wr, pif.ifid_flush, pif.idex_bubble, pif.pipe_hold, pif.state};
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
    end
    $display("step %-14s observed=%b expected=%b", e.tag, obs, e.v);
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    if (!rst_n) exp_stall = 0;
    total++;
    assert (stall_cnt === 3'(exp_stall)) else begin
      bad++;
      $error("FAIL %s_stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, exp_stall);
    end
    if (rst_n && !e.v[6] && exp_stall < 7) exp_stall++;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset", RSTV);
    rst_n = 1'b1;
    check("idle_run", RUNV);

    // Load-use through rs2, then the one-cycle LOAD_STALL with lu still present.
    pif.id_rs1 = 4'd0;
    pif.id_use_rs1 = 1'b1;
    lu_rs2(4'd5);
    check("lu_rs2", STALL);
    check("ls_masked", LSV);
    idle();
    check("after_ls", RUNV);

    // Matching rs1 that is not read must not stall; once read it must.
    pif.ex_mem_read = 1'b1;
    pif.ex_rd = 4'd7;
    pif.id_rs1 = 4'd7;
    pif.id_use_rs1 = 1'b0;
    pif.id_rs2 = 4'd3;
    pif.id_use_rs2 = 1'b1;
    check("rs1_unused", RUNV);
    pif.id_use_rs1 = 1'b1;
    check("lu_rs1", STALL);
    idle();
    check("ls_idle", LSV);
    check("run_again", RUNV);

    // Branch: three flush cycles, bubble only in the first; FLUSH ignores branch and lu.
    pif.ex_branch_taken = 1'b1;
    check("br_run", BRV);
    pif.ex_branch_taken = 1'b0;
    check("flush_a", FLV);
    pif.ex_branch_taken = 1'b1;
    lu_rs2(4'd5);
    check("flush_b_ign", FLV);
    idle();
    check("after_flush", RUNV);

    // Branch together with load-use: branch wins, no LOAD_STALL.
    pif.ex_branch_taken = 1'b1;
    lu_rs2(4'd5);
    check("br_and_lu", BRV);
    idle();
    check("bl_flush_a", FLV);
    check("bl_flush_b", FLV);
    check("bl_done", RUNV);

    // mem_busy for 4 cycles in FLUSH freezes the counter; one flush cycle remains.
    pif.ex_branch_taken = 1'b1;
    check("br_busy", BRV);
    pif.ex_branch_taken = 1'b0;
    check("bf_flush_a", FLV);
    pif.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) check($sformatf("busy_fl_%0d", i), mk(0, 0, 0, 0, 1, 2'd2));
    pif.mem_busy = 1'b0;
    check("bf_resume", FLV);
    check("bf_done", RUNV);

    // mem_busy holds LOAD_STALL, and outranks a branch in RUN.
    lu_rs2(4'd9);
    check("lu_pre_busy", STALL);
    pif.mem_busy = 1'b1;
    check("busy_ls", mk(0, 0, 0, 0, 1, 2'd1));
    pif.mem_busy = 1'b0;
    check("ls_release", LSV);
    idle();
    check("run_b", RUNV);
    pif.mem_busy = 1'b1;
    pif.ex_branch_taken = 1'b1;
    check("busy_br", mk(0, 0, 0, 0, 1, 2'd0));
    idle();
    check("busy_br_after", RUNV);

    // Branch taken while in LOAD_STALL is honoured.
    lu_rs2(4'd2);
    check("lu_pre_br", STALL);
    idle();
    pif.ex_branch_taken = 1'b1;
    check("ls_branch", mk(1, 1, 1, 1, 0, 2'd1));
    pif.ex_branch_taken = 1'b0;
    check("lsb_flush_a", FLV);
    check("lsb_flush_b", FLV);
    check("lsb_done", RUNV);

    // Reset pulsed mid-FLUSH aborts the flush immediately and leaves nothing pending.
    pif.ex_branch_taken = 1'b1;
    check("br_pre_rst", BRV);
    pif.ex_branch_taken = 1'b0;
    check("rst_flush_a", FLV);
    rst_n = 1'b0;
    check("rst_mid_flush", RSTV);
    rst_n = 1'b1;
    check("rst_release", RUNV);
    check("no_residual", RUNV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter FLUSH_CYC, default 1, SHALL set the number of cycles the FLUSH state lasts (legal range 1..7).
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 clk  in  1  pipeline clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_rs1, id_rs2  in  4 each  source registers of the instruction held in IF/ID.
REQ-007 id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
REQ-008 ex_rd  in  4  destination register of the instruction in EX.
REQ-009 ex_mem_read  in  1  the EX instruction is a load.
REQ-010 ex_branch_taken  in  1  the EX instruction redirects the PC.
REQ-011 mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
REQ-012 pc_wr  out  1  PC write enable.
REQ-013 ifid_wr  out  1  IF/ID write enable (drives the IF/ID register's wr_allow).
REQ-014 ifid_flush  out  1  load a NOP (32'd0) into IF/ID instead of the fetched word.
REQ-015 idex_bubble  out  1  load a NOP into ID/EX.
REQ-016 pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-017 state  out  2  current FSM state: RUN=0, LOAD_STALL=1, FLUSH=2.

Function
REQ-018 Load-use hazard (lu) SHALL be ex_mem_read AND ((id_use_rs1 AND id_rs1==ex_rd) OR (id_use_rs2 AND id_rs2==ex_rd)).
REQ-019 Outputs SHALL be combinational from state and inputs, with priority mem_busy > ex_branch_taken > lu.
REQ-020 Any state with mem_busy=1: pc_wr=0, ifid_wr=0, ifid_flush=0, idex_bubble=0, pipe_hold=1; state and flush counter SHALL hold.
REQ-021 RUN with no event: pc_wr=1, ifid_wr=1, all other outputs 0; stay in RUN.
REQ-022 RUN with ex_branch_taken: pc_wr=1, ifid_wr=1, ifid_flush=1, idex_bubble=1; load the flush counter with FLUSH_CYC-1; next state FLUSH if FLUSH_CYC>1, else RUN.
REQ-023 RUN with lu and no branch: pc_wr=0, ifid_wr=0, idex_bubble=1; next state LOAD_STALL.
REQ-024 LOAD_STALL SHALL last exactly one cycle. Outputs are as in RUN, with lu masked, but ex_branch_taken still honoured per REQ-022. Next state is RUN or FLUSH.
REQ-025 FLUSH: pc_wr=1, ifid_wr=1, ifid_flush=1, idex_bubble=0. Decrement the counter each cycle and return to RUN when it is 0. ex_branch_taken and lu SHALL be ignored.
REQ-026 The state encoding value 3 is unreachable; if entered, the FSM SHALL go to RUN on the next edge.

Reset
REQ-027 While rst_n=0: state=RUN, flush counter=0, stall counter=0.
REQ-028 While rst_n=0, outputs SHALL be forced to pc_wr=0, ifid_wr=0, ifid_flush=1, idex_bubble=1, pipe_hold=0.
REQ-029 Reset asserted mid-FLUSH or mid-LOAD_STALL SHALL abort the operation immediately, with no pending flush after release.
REQ-030 The first rising clk edge after rst_n rises SHALL behave as RUN.

Configuration
REQ-031 Macro PIPELINE_CTRL_STALL_CNT_EN SHALL compile in an output stall_cnt (CNT_W bits).
REQ-032 stall_cnt SHALL increment on each cycle where pc_wr=0 and rst_n=1, and saturate at all-ones.
REQ-033 Without PIPELINE_CTRL_STALL_CNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-034 ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle pc_wr=0, ifid_wr=0, idex_bubble=1, state=1 next cycle, then RUN; stall_cnt=1.
REQ-035 ex_branch_taken=1 in RUN, FLUSH_CYC=3 -> ifid_flush=1 for 3 consecutive cycles, idex_bubble=1 only in the first, state=2 for 2 cycles, then 0.
REQ-036 ex_branch_taken=1 and lu=1 in the same cycle -> branch response only, no LOAD_STALL entry.
REQ-037 mem_busy=1 for 4 cycles during FLUSH (FLUSH_CYC=3) -> pipe_hold=1, all enables 0, FLUSH resumes with its remaining count afterwards; stall_cnt +4.
REQ-038 rst_n pulsed low mid-FLUSH -> outputs forced per REQ-028 asynchronously, state=0 after release, no residual flush.
REQ-039 lu with id_use_rs1=0, id_rs1==ex_rd -> no stall.
